// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and bubble-masked control bits.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]        occ_q, occ_d;
  logic              accept;
  logic              xfer;

  // With the skid buffer, in_ready comes straight from a flop so the
  // downstream stall never ripples combinationally into the upstream stage.
  assign in_ready  = (SKID != 0) ? in_ready_q : (~main_v_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign xfer      = main_v_q & out_ready;
  assign out_valid = main_v_q;
  assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (SKID != 0) begin
      if (!main_v_q) begin
        if (accept) begin
          main_v_d    = 1'b1;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end else if (!skid_v_q) begin
        if (accept && xfer) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept) begin
          skid_v_d    = 1'b1;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (xfer) begin
          main_v_d = 1'b0;
        end
      end else if (xfer) begin
        skid_v_d    = 1'b0;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
      end
    end else begin
      if (accept) begin
        main_v_d    = 1'b1;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (xfer) begin
        main_v_d = 1'b0;
      end
    end

    // Flush only kills the valid bits; payload registers keep stale data.
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end

    occ_d      = {1'b0, main_v_d} + {1'b0, skid_v_d};
    in_ready_d = ~skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      occ_q       <= 2'd0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      occ_q       <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid-buffered 16/4 instance and a plain 32/1 instance;
// directed steps push expected words, monitors pop on every output transfer.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0]  a_in_ctrl, a_out_ctrl;
  logic [15:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0]  b_in_ctrl, b_out_ctrl;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .SKID(1)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(1), .SKID(0)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit started = 1'b0;

  logic [19:0] qa[$];
  logic [32:0] qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitors: pop on each transfer, and require zero control on bubbles.
  always @(negedge clk) begin
    if (started && !a_rst) begin
      if (a_out_valid) begin
        if (a_out_ready) begin
          if (qa.size() == 0) chk("a_unexpected_out", 64'(a_out_data), 64'hDEAD);
          else begin
            logic [19:0] e;
            e = qa.pop_front();
            chk("a_out_ctrl", 64'(a_out_ctrl), 64'(e[19:16]));
            chk("a_out_data", 64'(a_out_data), 64'(e[15:0]));
          end
        end
      end else chk("a_bubble_ctrl", 64'(a_out_ctrl), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (started && !b_rst) begin
      if (b_out_valid) begin
        if (b_out_ready) begin
          if (qb.size() == 0) chk("b_unexpected_out", 64'(b_out_data), 64'hDEAD);
          else begin
            logic [32:0] e;
            e = qb.pop_front();
            chk("b_out_ctrl", 64'(b_out_ctrl), 64'(e[32]));
            chk("b_out_data", 64'(b_out_data), 64'(e[31:0]));
          end
        end
      end else chk("b_bubble_ctrl", 64'(b_out_ctrl), 64'd0);
    end
  end

  // One cycle: drive at posedge+1, check pre-edge status at negedge.
  task automatic a_step(input bit r, input bit f, input bit iv, input logic [3:0] c,
                        input logic [15:0] d, input bit ordy, input bit erdy,
                        input logic [1:0] eocc, input bit eov);
    a_rst = r; a_flush = f; a_in_valid = iv; a_in_ctrl = c; a_in_data = d;
    a_out_ready = ordy;
    @(negedge clk);
    chk("a_in_ready", 64'(a_in_ready), 64'(erdy));
    chk("a_occupancy", 64'(a_occ), 64'(eocc));
    chk("a_out_valid", 64'(a_out_valid), 64'(eov));
    if (iv && erdy && !r && !f) qa.push_back({c, d});
    @(posedge clk);
    if (r || f) qa.delete();
    #1;
  endtask

  task automatic b_step(input bit iv, input logic c, input logic [31:0] d, input bit ordy,
                        input bit erdy, input logic [1:0] eocc, input bit eov);
    b_in_valid = iv; b_in_ctrl = c; b_in_data = d; b_out_ready = ordy;
    @(negedge clk);
    chk("b_in_ready", 64'(b_in_ready), 64'(erdy));
    chk("b_occupancy", 64'(b_occ), 64'(eocc));
    chk("b_out_valid", 64'(b_out_valid), 64'(eov));
    if (iv && erdy) qb.push_back({c, d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_ctrl = '0; a_in_data = '0;
    a_out_ready = 1'b1;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0;
    b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    chk("a_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_rst_out_ctrl", 64'(a_out_ctrl), 64'd0);
    chk("a_rst_out_data", 64'(a_out_data), 64'd0);
    chk("a_rst_occ", 64'(a_occ), 64'd0);
    chk("a_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("b_rst_out_data", 64'(b_out_data), 64'd0);
    chk("b_rst_in_ready", 64'(b_in_ready), 64'd1);
    b_rst = 1'b0;

    // Streaming at full rate
    for (int i = 1; i <= 5; i++)
      a_step(0, 0, 1, 4'b1010, 16'(i), 1, 1, (i == 1) ? 2'd0 : 2'd1, (i != 1));
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 1, 2'd1, 1);
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 1, 2'd0, 0);

    // Skid fill and drain
    a_step(0, 0, 1, 4'b0110, 16'h00A1, 1, 1, 2'd0, 0);
    a_step(0, 0, 1, 4'b0110, 16'h00A2, 0, 1, 2'd1, 1);
    a_step(0, 0, 0, 4'b0000, 16'h0, 0, 0, 2'd2, 1);
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 0, 2'd2, 1);
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 1, 2'd1, 1);
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 1, 2'd0, 0);

    // Flush while full with 0x00FF offered
    a_step(0, 0, 1, 4'b1010, 16'h00B1, 0, 1, 2'd0, 0);
    a_step(0, 0, 1, 4'b1010, 16'h00B2, 0, 1, 2'd1, 1);
    a_step(0, 1, 1, 4'b1111, 16'h00FF, 0, 0, 2'd2, 1);
    chk("a_flush_out_ctrl", 64'(a_out_ctrl), 64'd0);
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 1, 2'd0, 0);

    // Flush coincident with an output transfer and an accept
    a_step(0, 0, 1, 4'b1100, 16'h00C1, 1, 1, 2'd0, 0);
    a_step(0, 1, 1, 4'b1111, 16'h00FF, 1, 1, 2'd1, 1);
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 1, 2'd0, 0);
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 1, 2'd0, 0);

    // Control bits with in_valid low never reach the output
    for (int i = 0; i < 6; i++)
      a_step(0, 0, 0, 4'b1111, 16'hFFFF, (i < 3), 1, 2'd0, 0);

    // Reset together with flush while full
    a_step(0, 0, 1, 4'b0011, 16'h00D1, 0, 1, 2'd0, 0);
    a_step(0, 0, 1, 4'b0011, 16'h00D2, 0, 1, 2'd1, 1);
    a_step(1, 1, 1, 4'b0011, 16'h00D3, 0, 0, 2'd2, 1);
    chk("a_rf_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_rf_out_ctrl", 64'(a_out_ctrl), 64'd0);
    chk("a_rf_out_data", 64'(a_out_data), 64'd0);
    chk("a_rf_occ", 64'(a_occ), 64'd0);
    chk("a_rf_in_ready", 64'(a_in_ready), 64'd1);
    a_step(0, 0, 0, 4'b0000, 16'h0, 1, 1, 2'd0, 0);

    // Single-entry instance: in_ready tracks out_ready in the same cycle
    b_step(1, 1'b1, 32'hDEAD0001, 1, 1, 2'd0, 0);
    b_step(1, 1'b1, 32'hDEAD0002, 1, 1, 2'd1, 1);
    b_step(1, 1'b0, 32'hDEAD0003, 0, 0, 2'd1, 1);
    b_step(1, 1'b0, 32'hDEAD0003, 1, 1, 2'd1, 1);
    b_step(0, 1'b0, 32'h0, 1, 1, 2'd1, 1);
    b_step(0, 1'b1, 32'hFFFFFFFF, 1, 1, 2'd0, 0);
    b_step(1, 1'b0, 32'h12345678, 0, 1, 2'd0, 0);
    b_step(0, 1'b0, 32'h0, 1, 1, 2'd1, 1);
    b_step(0, 1'b0, 32'h0, 1, 1, 2'd0, 0);

    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
